// File: rtl/cubehash_round_engine.sv
// CubeHash permutation engine: UNROLL rounds per clock, runtime round count.
// Optional CUBEHASH_FINAL_XOR_EN fuses the finalisation XOR into the load.
module cubehash_round_engine #(
  parameter int UNROLL = 2,
  parameter int NR_W   = 8,
  parameter int ROT_A  = 7,
  parameter int ROT_B  = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1023:0]     in_state,
  input  logic [NR_W-1:0]   num_rounds,
`ifdef CUBEHASH_FINAL_XOR_EN
  input  logic              in_final,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1023:0]     out_state
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t            r_st;
  state_t            w_st_nx;
  logic [1023:0]     r_state;
  logic [NR_W-1:0]   r_rem;
  logic              w_acc;
  logic              w_last;
  logic [NR_W-1:0]   w_step;
  logic [1023:0]     w_load;
  logic [1023:0]     w_next;
  logic [1023:0]     w_stage [UNROLL+1];

  localparam logic [NR_W-1:0] UST = NR_W'(UNROLL);

  function automatic logic [31:0] rl_a(input logic [31:0] x);
    return (x << ROT_A) | (x >> (32 - ROT_A));
  endfunction

  function automatic logic [31:0] rl_b(input logic [31:0] x);
    return (x << ROT_B) | (x >> (32 - ROT_B));
  endfunction

  // Swaps folded into index maps: i^8, i^2, i^4, i^1.
  function automatic logic [1023:0] cube_round(
    input logic [1023:0] s
  );
    logic [31:0] a0 [16];
    logic [31:0] b0 [16];
    logic [31:0] b1 [16];
    logic [31:0] a2 [16];
    logic [31:0] b2 [16];
    logic [31:0] a3 [16];
    logic [1023:0] o;
    o = '0;
    for (int i = 0; i < 16; i++) begin
      a0[i] = s[1023-32*i -: 32];
      b0[i] = s[511-32*i -: 32];
    end
    for (int i = 0; i < 16; i++)
      b1[i] = b0[i] + a0[i];
    for (int i = 0; i < 16; i++)
      a2[i] = rl_a(a0[i ^ 8]) ^ b1[i];
    for (int i = 0; i < 16; i++)
      b2[i] = b1[i ^ 2] + a2[i];
    for (int i = 0; i < 16; i++)
      a3[i] = rl_b(a2[i ^ 4]) ^ b2[i];
    for (int i = 0; i < 16; i++) begin
      o[1023-32*i -: 32] = a3[i];
      o[511-32*i -: 32]  = b2[i ^ 1];
    end
    return o;
  endfunction

  assign w_stage[0] = r_state;

  for (genvar g = 0; g < UNROLL; g++) begin : g_rnd
    assign w_stage[g+1] = cube_round(w_stage[g]);
  end

  assign w_step = (r_rem < UST) ? r_rem : UST;
  assign w_last = (r_rem <= UST);

`ifdef CUBEHASH_FINAL_XOR_EN
  assign w_load = in_state ^ {1023'b0, in_final};
`else
  assign w_load = in_state;
`endif

  // Pick the stage output that applies exactly min(UNROLL, remaining) rounds.
  always_comb begin
    w_next = w_stage[UNROLL];
    for (int k = 1; k < UNROLL; k++)
      if (r_rem == NR_W'(k))
        w_next = w_stage[k];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_st <= S_IDLE;
    else        r_st <= w_st_nx;
  end

  // Next-state and handshake outputs.
  always_comb begin
    w_st_nx   = r_st;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_acc     = 1'b0;
    unique case (r_st)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_acc   = 1'b1;
          w_st_nx = (num_rounds == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) w_st_nx = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_st_nx = S_IDLE;
      end
      default: w_st_nx = S_IDLE;
    endcase
  end

  // State word and round counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= '0;
      r_rem   <= '0;
    end else if (w_acc) begin
      r_state <= w_load;
      r_rem   <= num_rounds;
    end else if (r_st == S_RUN) begin
      r_state <= w_next;
      r_rem   <= r_rem - w_step;
    end
  end

  assign out_state = r_state;

endmodule

// File: tb/tb_cubehash_round_engine.sv
// Bench for cubehash_round_engine: two instances (UNROLL 2 and 4),
// queued expectations checked by per-instance output monitors.
module tb_cubehash_round_engine;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic          va = 0, ra, fa = 0, ova, ora = 1;
  logic [1023:0] sa = '0, osa;
  logic [7:0]    na = '0;
  logic          vb = 0, rb, fb = 0, ovb, orb = 1;
  logic [1023:0] sb = '0, osb;
  logic [7:0]    nb = '0;

  cubehash_round_engine #(.UNROLL(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(va), .in_ready(ra),
    .in_state(sa), .num_rounds(na),
`ifdef CUBEHASH_FINAL_XOR_EN
    .in_final(fa),
`endif
    .out_valid(ova), .out_ready(ora),
    .out_state(osa)
  );

  cubehash_round_engine #(.UNROLL(4)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(vb), .in_ready(rb),
    .in_state(sb), .num_rounds(nb),
`ifdef CUBEHASH_FINAL_XOR_EN
    .in_final(fb),
`endif
    .out_valid(ovb), .out_ready(orb),
    .out_state(osb)
  );

  typedef struct {
    logic [1023:0] exp;
    int            lat;
    int            acc;
    bit            hchk;
    logic [127:0]  hw;
  } ent_t;

  ent_t qa[$];
  ent_t qb[$];

  function automatic logic [31:0] rl(input logic [31:0] x, input int r);
    return (x << r) | (x >> (32 - r));
  endfunction

  function automatic logic [1023:0] mround(input logic [1023:0] s);
    logic [31:0] x [32];
    logic [31:0] t;
    logic [1023:0] o;
    for (int i = 0; i < 32; i++) x[i] = s[1023-32*i -: 32];
    for (int i = 0; i < 16; i++) x[16+i] = x[16+i] + x[i];
    for (int i = 0; i < 16; i++) x[i] = rl(x[i], 7);
    for (int i = 0; i < 8; i++) begin
      t = x[i]; x[i] = x[i+8]; x[i+8] = t;
    end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[16+i];
    for (int i = 0; i < 16; i++)
      if ((i % 4) < 2) begin
        t = x[16+i]; x[16+i] = x[18+i]; x[18+i] = t;
      end
    for (int i = 0; i < 16; i++) x[16+i] = x[16+i] + x[i];
    for (int i = 0; i < 16; i++) x[i] = rl(x[i], 11);
    for (int i = 0; i < 16; i++)
      if ((i % 8) < 4) begin
        t = x[i]; x[i] = x[i+4]; x[i+4] = t;
      end
    for (int i = 0; i < 16; i++) x[i] = x[i] ^ x[16+i];
    for (int i = 0; i < 16; i += 2) begin
      t = x[16+i]; x[16+i] = x[17+i]; x[17+i] = t;
    end
    for (int i = 0; i < 32; i++) o[1023-32*i -: 32] = x[i];
    return o;
  endfunction

  function automatic logic [1023:0] mrounds(
    input logic [1023:0] s, input int n
  );
    logic [1023:0] v;
    v = s;
    for (int i = 0; i < n; i++) v = mround(v);
    return v;
  endfunction

  function automatic logic [1023:0] rnd_state();
    logic [1023:0] s;
    for (int i = 0; i < 32; i++) s[1023-32*i -: 32] = $urandom;
    return s;
  endfunction

  task automatic chk_i(input string nm, input int a, input int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic chk_st(
    input string nm, input logic [1023:0] a, input logic [1023:0] e
  );
    int w;
    total++;
    if (a !== e) begin
      bad++;
      w = 0;
      for (int i = 31; i >= 0; i--)
        if (a[1023-32*i -: 32] !== e[1023-32*i -: 32]) w = i;
      $display("FAIL %s word%0d got %h want %h", nm, w,
               a[1023-32*w -: 32], e[1023-32*w -: 32]);
    end
  endtask

  task automatic job(
    input bit sel, input logic [1023:0] st, input int n,
    input bit fin, input logic [1023:0] exp,
    input bit hchk, input logic [127:0] hw
  );
    ent_t e;
    int t;
    int u;
    t = 0;
    u = sel ? 4 : 2;
    @(negedge clk);
    while (!(sel ? rb : ra) && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (t >= 300) begin
      chk_i("in_ready_timeout", 0, 1);
      return;
    end
    if (sel) begin
      vb = 1; sb = st; nb = 8'(n); fb = fin;
    end else begin
      va = 1; sa = st; na = 8'(n); fa = fin;
    end
    @(posedge clk);
    #1;
    va = 0;
    vb = 0;
    e.exp = exp;
    e.lat = (n + u - 1) / u;
    e.acc = cyc;
    e.hchk = hchk;
    e.hw = hw;
    if (sel) qb.push_back(e);
    else     qa.push_back(e);
  endtask

  task automatic wait_empty(input bit sel);
    int t;
    t = 0;
    while ((sel ? qb.size() : qa.size()) != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      chk_i(sel ? "B_result_timeout" : "A_result_timeout", 0, 1);
      if (sel) qb.delete();
      else     qa.delete();
    end
    @(negedge clk);
  endtask

  bit pa = 0;
  int fca = 0;
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) pa = 0;
    else begin
      if (ova && !pa) fca = cyc;
      pa = ova;
      if (ova && ora) begin
        if (qa.size() == 0) chk_i("A_unexpected_out", 1, 0);
        else begin
          e = qa.pop_front();
          chk_st("A_state", osa, e.exp);
          chk_i("A_latency", fca - e.acc, e.lat);
          if (e.hchk) begin
            total++;
            if (osa[1023:896] !== e.hw) begin
              bad++;
              $display("FAIL A_iv_words got %h want %h",
                       osa[1023:896], e.hw);
            end
          end
        end
      end
    end
  end

  bit pb = 0;
  int fcb = 0;
  always @(negedge clk) begin
    ent_t e;
    if (!rst_n) pb = 0;
    else begin
      if (ovb && !pb) fcb = cyc;
      pb = ovb;
      if (ovb && orb) begin
        if (qb.size() == 0) chk_i("B_unexpected_out", 1, 0);
        else begin
          e = qb.pop_front();
          chk_st("B_state", osb, e.exp);
          chk_i("B_latency", fcb - e.acc, e.lat);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1023:0] s;
    logic [1023:0] x;
    logic [127:0]  hw;
    bit            sawv;

    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk_i("rst_A_in_ready", int'(ra), 1);
    chk_i("rst_A_out_valid", int'(ova), 0);
    chk_st("rst_A_out_state", osa, '0);
    chk_i("rst_B_in_ready", int'(rb), 1);
    chk_i("rst_B_out_valid", int'(ovb), 0);
    chk_st("rst_B_out_state", osb, '0);

    s = '0;
    s[1023:928] = {32'd64, 32'd32, 32'd16};
    hw = {32'h2AEA2A61, 32'h50F494D4, 32'h2D538B8B, 32'h4167D83E};
    job(0, s, 160, 0, mrounds(s, 160), 1, hw);
    wait_empty(0);

    s = rnd_state();
    job(1, s, 7, 0, mrounds(s, 7), 0, '0);
    wait_empty(1);
    s = rnd_state();
    job(1, s, 16, 0, mrounds(s, 16), 0, '0);
    wait_empty(1);
    s = rnd_state();
    job(0, s, 3, 0, mrounds(s, 3), 0, '0);
    wait_empty(0);

    s = rnd_state();
    ora = 0;
    job(0, s, 0, 0, s, 0, '0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_i("bp_out_valid", int'(ova), 1);
      chk_st("bp_out_state", osa, s);
      chk_i("bp_in_ready", int'(ra), 0);
    end
    ora = 1;
    wait_empty(0);

    s = rnd_state();
    job(1, s, 160, 0, mrounds(s, 160), 0, '0);
    sawv = 0;
    repeat (10) begin
      @(negedge clk);
      if (ovb) sawv = 1;
    end
    chk_i("abort_no_valid", int'(sawv), 0);
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    void'(qb.pop_back());
    chk_i("mid_rst_in_ready", int'(rb), 1);
    chk_i("mid_rst_out_valid", int'(ovb), 0);
    chk_st("mid_rst_out_state", osb, '0);
    s = rnd_state();
    job(1, s, 16, 0, mrounds(s, 16), 0, '0);
    wait_empty(1);

`ifdef CUBEHASH_FINAL_XOR_EN
    s = rnd_state();
    s[31:0] = 32'hFFFFFFFF;
    x = s;
    x[31:0] = 32'hFFFFFFFE;
    job(0, s, 0, 1, x, 0, '0);
    wait_empty(0);
`else
    x = '0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
